// File: rtl/sender_pkg.sv
// Shared definitions for the ARQ sender: FSM encoding, default frame/timeout/retry
// settings and a counter-width helper.
package sender_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RETRANS  = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_FAIL     = 3'd5
    } arq_state_t;

    localparam int unsigned DEF_FRAME_LEN   = 64;
    localparam int unsigned DEF_TIMEOUT_CYC = 4096;
    localparam int unsigned DEF_MAX_RETRY   = 3;
    localparam int unsigned RETRY_W         = 2;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // States in which the mapper must not start a new frame.
    function automatic logic st_holds_map(input arq_state_t s);
        return (s == ST_WAIT_ACK) || (s == ST_RETRANS) || (s == ST_FAIL);
    endfunction

endpackage

// File: rtl/arq_ctrl_if.sv
// Frame, replay and ACK strobes between the mapper/line-FIFO/receive side and arq_ctrl.
interface arq_ctrl_if;

    logic i_frame_valid;
    logic i_frame_fas;
    logic i_replay_beat;
    logic i_ack_valid;
    logic i_ack_ok;

    modport master (
        output i_frame_valid,
        output i_frame_fas,
        output i_replay_beat,
        output i_ack_valid,
        output i_ack_ok
    );

    modport slave (
        input  i_frame_valid,
        input  i_frame_fas,
        input  i_replay_beat,
        input  i_ack_valid,
        input  i_ack_ok
    );

endinterface

// File: rtl/arq_timer.sv
// ACK timeout timer: counts while enabled, holds at its last value, expires on
// the cycle the count reaches TIMEOUT_CYC-1.
module arq_timer
    import sender_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned TW = cnt_width(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] ONE  = TW'(1);

    logic [TW-1:0] r_cnt;
    logic          w_at_last;

    assign w_at_last = (r_cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !w_at_last) begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_expire = i_enable & ~i_clear & w_at_last;

endmodule

// File: rtl/arq_ctrl.sv
// ARQ sender controller: tracks each mapped frame, waits for ACK/NAK, replays
// the frame from the line FIFO on NAK/timeout and gives up after MAX_RETRY.
module arq_ctrl
    import sender_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = DEF_FRAME_LEN,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_arq_en,
    input  logic               i_fail_clr,
    arq_ctrl_if.slave          i_link,
    output logic               o_map_hold,
    output logic               o_retrans_req,
    output logic               o_lf_flush,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic               o_fail,
    output logic               o_busy
);

    localparam int unsigned CW = cnt_width(FRAME_LEN + 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LEN_LAST = CW'(FRAME_LEN - 1);
    localparam logic [RETRY_W-1:0] MAXR    = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] R_ONE   = RETRY_W'(1);

    arq_state_t         r_state;
    arq_state_t         w_state_nxt;
    logic [CW-1:0]      r_byte_cnt;
    logic [CW-1:0]      w_byte_nxt;
    logic [RETRY_W-1:0] r_retry;
    logic [RETRY_W-1:0] w_retry_nxt;

    logic r_map_hold;
    logic r_retrans_req;
    logic r_lf_flush;
    logic r_fail;
    logic r_busy;

    logic w_tmr_en;
    logic w_tmr_clr;
    logic w_tmr_expire;
    logic w_ack_good;
    logic w_ack_bad;

    // Timer runs only while waiting; any other state leaves it cleared, so each
    // entry into WAIT_ACK starts counting from zero.
    assign w_tmr_en  = (r_state == ST_WAIT_ACK);
    assign w_tmr_clr = ~w_tmr_en;

    arq_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (w_tmr_clr),
        .i_enable (w_tmr_en),
        .o_expire (w_tmr_expire)
    );

    assign w_ack_good = i_link.i_ack_valid &  i_link.i_ack_ok;
    assign w_ack_bad  = i_link.i_ack_valid & ~i_link.i_ack_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte_cnt;
        w_retry_nxt = r_retry;

        unique case (r_state)
            ST_IDLE: begin
                if (i_link.i_frame_valid && i_link.i_frame_fas) begin
                    w_state_nxt = ST_SEND;
                    w_byte_nxt  = ONE;
                end
            end
            ST_SEND: begin
                if (i_link.i_frame_valid) begin
                    if (i_link.i_frame_fas) begin
                        w_byte_nxt = ONE;
                    end else if (r_byte_cnt == LEN_LAST) begin
                        w_byte_nxt  = '0;
                        w_state_nxt = i_arq_en ? ST_WAIT_ACK : ST_FLUSH;
                    end else begin
                        w_byte_nxt = r_byte_cnt + ONE;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // A good ACK outranks a coincident timeout expiry.
                if (!i_arq_en || w_ack_good) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_ack_bad || w_tmr_expire) begin
                    if (r_retry < MAXR) begin
                        w_state_nxt = ST_RETRANS;
                        w_retry_nxt = r_retry + R_ONE;
                    end else begin
                        w_state_nxt = ST_FAIL;
                    end
                end
            end
            ST_RETRANS: begin
                if (i_link.i_replay_beat) begin
                    if (r_byte_cnt == LEN_LAST) begin
                        w_byte_nxt  = '0;
                        w_state_nxt = ST_WAIT_ACK;
                    end else begin
                        w_byte_nxt = r_byte_cnt + ONE;
                    end
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAIL: begin
                if (i_fail_clr) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_byte_nxt  = '0;
            end
        endcase

        if (w_state_nxt == ST_FLUSH) begin
            w_retry_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_byte_cnt    <= '0;
            r_retry       <= '0;
            r_map_hold    <= 1'b0;
            r_retrans_req <= 1'b0;
            r_lf_flush    <= 1'b0;
            r_fail        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_byte_cnt    <= w_byte_nxt;
            r_retry       <= w_retry_nxt;
            r_map_hold    <= st_holds_map(w_state_nxt);
            r_retrans_req <= (w_state_nxt == ST_RETRANS);
            r_lf_flush    <= (w_state_nxt == ST_FLUSH);
            r_fail        <= (w_state_nxt == ST_FAIL);
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_map_hold    = r_map_hold;
    assign o_retrans_req = r_retrans_req;
    assign o_lf_flush    = r_lf_flush;
    assign o_retry_cnt   = r_retry;
    assign o_fail        = r_fail;
    assign o_busy        = r_busy;

    a_flush_single: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_lf_flush |=> !r_lf_flush);

    a_retry_sat: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        r_retry <= MAXR);

endmodule
